// File: rtl/rdma_int_pkg.sv
// rdma_int_pkg: shared constants and FSM encoding for the RDMA interrupt scheduler.
`ifndef RDMA_MSIX_NUM_LOG
`define RDMA_MSIX_NUM_LOG 5
`endif

package rdma_int_pkg;
    localparam int MSIX_NUM_LOG       = `RDMA_MSIX_NUM_LOG;
    localparam int ADDR_LO            = 0;
    localparam int ADDR_HI            = 32;
    localparam int DATA               = 64;
    localparam int CTRL               = 96;
    localparam int MASK_BIT           = 96;
    localparam int RETRY_INTERVAL_DEF = 256;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ISSUE  = 5'b00010,
        S_WAIT   = 5'b00100,
        S_DECIDE = 5'b01000,
        S_SEND   = 5'b10000
    } state_e;
endpackage

// File: rtl/rdma_int_rr_arb.sv
// rdma_int_rr_arb: N-way round-robin arbiter; searches upward from ptr_i with wrap.
module rdma_int_rr_arb #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);
    int j;

    // Scanning from the farthest offset down lets the nearest requester win last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end
endmodule

// File: rtl/rdma_int_sched.sv
// rdma_int_sched: arbitrates interrupt requests onto the MSI-X table port, decodes
// entries into MSI-X write descriptors and retries masked (pending) vectors.
module rdma_int_sched
    import rdma_int_pkg::*;
#(
    parameter int REQ_NUM        = 4,
    parameter int VEC_LOG        = MSIX_NUM_LOG,
    parameter int RETRY_INTERVAL = RETRY_INTERVAL_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [REQ_NUM-1:0]         req_valid,
    input  logic [REQ_NUM*VEC_LOG-1:0] req_num,
    output logic [REQ_NUM-1:0]         req_ready,
    output logic                       tbl_req_valid,
    output logic [VEC_LOG-1:0]         tbl_req_num,
    input  logic                       tbl_req_ready,
    input  logic                       tbl_rsp_valid,
    input  logic [127:0]               tbl_rsp_data,
    output logic                       tbl_rsp_ready,
    output logic                       msg_valid,
    output logic [63:0]                msg_addr,
    output logic [31:0]                msg_data,
    input  logic                       msg_ready,
    output logic [VEC_LOG:0]           pend_cnt,
    output logic                       err_drop
);
    localparam int NV = 1 << VEC_LOG;
    localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int TW = $clog2(RETRY_INTERVAL);

    state_e              state_q, state_d;
    logic [RW-1:0]       rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [REQ_NUM-1:0]  gnt;
    logic [VEC_LOG-1:0]  ret_ptr_q, ret_ptr_d, idx_q, idx_d, pend_idx;
    logic [NV-1:0]       pending_q, pending_d, pend_gnt;
    logic [TW-1:0]       timer_q, timer_d;
    logic [MASK_BIT:0]   entry_q, entry_d;
    logic [VEC_LOG:0]    pend_cnt_q;
    logic                retry_go, misaligned, unused_ctrl;

    rdma_int_rr_arb #(.N(REQ_NUM)) u_req_arb (
        .req_i(req_valid), .ptr_i(rr_ptr_q), .gnt_o(gnt), .idx_o(gnt_idx)
    );

    rdma_int_rr_arb #(.N(NV)) u_pend_arb (
        .req_i(pending_q), .ptr_i(ret_ptr_q), .gnt_o(pend_gnt), .idx_o(pend_idx)
    );

    assign unused_ctrl   = ^tbl_rsp_data[127:MASK_BIT+1];
    assign misaligned    = |entry_q[ADDR_LO +: 2];
    assign tbl_req_num   = idx_q;
    assign msg_addr      = {entry_q[ADDR_HI +: 32], entry_q[ADDR_LO +: 32]};
    assign msg_data      = entry_q[DATA +: 32];
    assign pend_cnt      = pend_cnt_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        ret_ptr_d     = ret_ptr_q;
        idx_d         = idx_q;
        entry_d       = entry_q;
        pending_d     = pending_q;
        req_ready     = '0;
        tbl_req_valid = 1'b0;
        tbl_rsp_ready = 1'b0;
        msg_valid     = 1'b0;
        err_drop      = 1'b0;
        retry_go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = gnt;
                if (|req_valid) begin
                    idx_d    = req_num[int'(gnt_idx)*VEC_LOG +: VEC_LOG];
                    rr_ptr_d = (gnt_idx == RW'(REQ_NUM - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d  = S_ISSUE;
                end else if (|pend_gnt && timer_q == TW'(RETRY_INTERVAL - 1)) begin
                    retry_go  = 1'b1;
                    idx_d     = pend_idx;
                    ret_ptr_d = pend_idx + 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tbl_req_valid = 1'b1;
                state_d       = tbl_req_ready ? S_WAIT : S_ISSUE;
            end
            S_WAIT: begin
                tbl_rsp_ready = 1'b1;
                if (tbl_rsp_valid) begin
                    entry_d = tbl_rsp_data[MASK_BIT:0];
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                pending_d[idx_q] = entry_q[MASK_BIT];
                err_drop         = !entry_q[MASK_BIT] && misaligned;
                state_d          = (entry_q[MASK_BIT] || misaligned) ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                msg_valid = 1'b1;
                state_d   = msg_ready ? S_IDLE : S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
        // The timer only runs while idle-waiting on a pending retry; anything else clears it.
        timer_d = (state_q == S_IDLE && !(|req_valid) && |pend_gnt && !retry_go)
                ? ((timer_q == TW'(RETRY_INTERVAL - 1)) ? timer_q : timer_q + 1'b1)
                : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            ret_ptr_q  <= '0;
            idx_q      <= '0;
            entry_q    <= '0;
            pending_q  <= '0;
            timer_q    <= '0;
            pend_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            ret_ptr_q  <= ret_ptr_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            pend_cnt_q <= (VEC_LOG + 1)'($countones(pending_q));
        end
    end
endmodule

// File: tb/tb_rdma_int_sched.sv
// tb_rdma_int_sched: directed scenarios for rdma_int_sched with a behavioural MSI-X table.
module tb_rdma_int_sched;
    localparam int RN = 4;
    localparam int VL = 5;
    localparam int RI = 256;
    localparam int NV = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [RN-1:0]    req_valid, req_ready;
    logic [RN*VL-1:0] req_num;
    logic             tbl_req_valid, tbl_req_ready, tbl_rsp_valid, tbl_rsp_ready;
    logic [VL-1:0]    tbl_req_num;
    logic [127:0]     tbl_rsp_data;
    logic             msg_valid, msg_ready, err_drop;
    logic [63:0]      msg_addr;
    logic [31:0]      msg_data;
    logic [VL:0]      pend_cnt;

    rdma_int_sched #(.REQ_NUM(RN), .VEC_LOG(VL), .RETRY_INTERVAL(RI)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
        .tbl_req_valid(tbl_req_valid), .tbl_req_num(tbl_req_num), .tbl_req_ready(tbl_req_ready),
        .tbl_rsp_valid(tbl_rsp_valid), .tbl_rsp_data(tbl_rsp_data), .tbl_rsp_ready(tbl_rsp_ready),
        .msg_valid(msg_valid), .msg_addr(msg_addr), .msg_data(msg_data), .msg_ready(msg_ready),
        .pend_cnt(pend_cnt), .err_drop(err_drop)
    );

    logic [127:0] tbl [NV];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int err_cnt = 0;
    logic [63:0] m_addr[$];
    logic [31:0] m_data[$];
    int          m_cyc[$];
    logic [RN-1:0] g_oh[$];
    int          g_cyc[$];
    logic [VL-1:0] t_num[$];
    int          t_cyc[$];
    int          r_cyc[$];
    logic        rsp_rq, rsp_rs;
    logic [VL-1:0] rsp_n;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (msg_valid && msg_ready) begin
                m_addr.push_back(msg_addr); m_data.push_back(msg_data); m_cyc.push_back(cyc);
            end
            if (|req_ready) begin
                g_oh.push_back(req_ready); g_cyc.push_back(cyc);
            end
            if (tbl_req_valid && tbl_req_ready) begin
                t_num.push_back(tbl_req_num); t_cyc.push_back(cyc);
            end
            if (tbl_rsp_valid && tbl_rsp_ready) r_cyc.push_back(cyc);
            if (err_drop) err_cnt++;
        end
    end

    // Table model: answers each accepted lookup one cycle later, holds until taken.
    initial begin
        tbl_rsp_valid = 1'b0;
        tbl_rsp_data  = '0;
        forever begin
            @(negedge clk);
            rsp_rq = tbl_req_valid && tbl_req_ready;
            rsp_rs = tbl_rsp_valid && tbl_rsp_ready;
            rsp_n  = tbl_req_num;
            @(posedge clk); #1;
            if (rsp_rs || !rst_n) tbl_rsp_valid = 1'b0;
            if (rsp_rq && rst_n) begin
                tbl_rsp_valid = 1'b1;
                tbl_rsp_data  = tbl[rsp_n];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [63:0] qa(int i); return i < m_addr.size() ? m_addr[i] : 'x; endfunction
    function automatic logic [31:0] qd(int i); return i < m_data.size() ? m_data[i] : 'x; endfunction
    function automatic int qmc(int i); return i < m_cyc.size() ? m_cyc[i] : -1000; endfunction
    function automatic logic [RN-1:0] qg(int i); return i < g_oh.size() ? g_oh[i] : 'x; endfunction
    function automatic int qgc(int i); return i < g_cyc.size() ? g_cyc[i] : -1000; endfunction
    function automatic logic [VL-1:0] qt(int i); return i < t_num.size() ? t_num[i] : 'x; endfunction
    function automatic int qtc(int i); return i < t_cyc.size() ? t_cyc[i] : -1000; endfunction
    function automatic int qrc(int i); return i < r_cyc.size() ? r_cyc[i] : -1000; endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        m_addr.delete(); m_data.delete(); m_cyc.delete();
        g_oh.delete(); g_cyc.delete(); t_num.delete(); t_cyc.delete(); r_cyc.delete();
        err_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_num = '0;
        msg_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic request(int r, int v);
        req_num[r*VL +: VL] = VL'(v);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[r]) break;
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(int n, int bound);
        for (int i = 0; i < bound && r_cyc.size() < n; i++) tick(1);
    endtask

    task automatic wait_treq(int n, int bound);
        for (int i = 0; i < bound && t_num.size() < n; i++) tick(1);
    endtask

    task automatic wait_msgs(int n, int bound);
        for (int i = 0; i < bound && m_addr.size() < n; i++) tick(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++; if (req_ready !== 4'b0) $display("FAIL rst_req_ready got=%h exp=0", req_ready); else passed++;
        checks++; if (tbl_req_valid !== 1'b0) $display("FAIL rst_tbl_req_valid got=%b exp=0", tbl_req_valid); else passed++;
        checks++; if (tbl_rsp_ready !== 1'b0) $display("FAIL rst_tbl_rsp_ready got=%b exp=0", tbl_rsp_ready); else passed++;
        checks++; if (msg_valid !== 1'b0) $display("FAIL rst_msg_valid got=%b exp=0", msg_valid); else passed++;
        checks++; if (err_drop !== 1'b0) $display("FAIL rst_err_drop got=%b exp=0", err_drop); else passed++;
        checks++; if (tbl_req_num !== '0) $display("FAIL rst_tbl_req_num got=%h exp=0", tbl_req_num); else passed++;
        checks++; if ({msg_addr, msg_data} !== 96'h0) $display("FAIL rst_msg got=%h/%h exp=0/0", msg_addr, msg_data); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL rst_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
        do_reset();
    endtask

    task automatic test_single();
        clear_logs();
        tbl[5] = {32'h0, 32'h45, 32'h1, 32'hFEE0_0000};
        request(1, 5);
        wait_msgs(1, 50);
        tick(3);
        checks++; if (qg(0) !== 4'b0010 || g_oh.size() != 1) $display("FAIL single_grant got=%h n=%0d exp=2 n=1", qg(0), g_oh.size()); else passed++;
        checks++; if (qt(0) !== 5'd5) $display("FAIL single_tbl_num got=%0d exp=5", qt(0)); else passed++;
        checks++; if (qtc(0) - qgc(0) != 1) $display("FAIL single_issue_lat got=%0d exp=1", qtc(0) - qgc(0)); else passed++;
        checks++; if (m_addr.size() != 1) $display("FAIL single_msg_count got=%0d exp=1", m_addr.size()); else passed++;
        checks++; if (qa(0) !== 64'h1_FEE0_0000) $display("FAIL single_msg_addr got=%h exp=1fee00000", qa(0)); else passed++;
        checks++; if (qd(0) !== 32'h45) $display("FAIL single_msg_data got=%h exp=45", qd(0)); else passed++;
        checks++; if (qmc(0) - qrc(0) != 2) $display("FAIL single_msg_lat got=%0d exp=2", qmc(0) - qrc(0)); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL single_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) tbl[i] = {32'h0, 32'h100 + 32'(i), 32'h1, 32'hFEE0_0000 + 32'(i * 16)};
        req_num = {5'd3, 5'd2, 5'd1, 5'd0};
        req_valid = 4'hF;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (g_oh.size() >= 5) break;
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_msgs(5, 100);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            checks++; if (qg(i) !== 4'(1 << (i % 4))) $display("FAIL b2b_grant%0d got=%h exp=%h", i, qg(i), 4'(1 << (i % 4))); else passed++;
        end
        checks++; if (qgc(1) - qgc(0) != 5) $display("FAIL b2b_grant_gap got=%0d exp=5", qgc(1) - qgc(0)); else passed++;
        for (int i = 0; i < 5; i++) begin
            checks++; if (qd(i) !== 32'h100 + 32'(i % 4)) $display("FAIL b2b_data%0d got=%h exp=%h", i, qd(i), 32'h100 + 32'(i % 4)); else passed++;
        end
        checks++; if (qa(2) !== 64'h1_FEE0_0020) $display("FAIL b2b_addr2 got=%h exp=1fee00020", qa(2)); else passed++;
    endtask

    task automatic test_masked_retry();
        int t;
        clear_logs();
        tbl[7] = {32'h1, 32'h77, 32'h1, 32'hFEE0_0070};
        request(0, 7);
        wait_rsp(1, 20);
        t = qrc(0);
        tbl[7][96] = 1'b0;
        tick(4);
        checks++; if (pend_cnt !== 6'd1) $display("FAIL masked_pend_cnt got=%0d exp=1", pend_cnt); else passed++;
        checks++; if (m_addr.size() != 0) $display("FAIL masked_no_msg got=%0d exp=0", m_addr.size()); else passed++;
        wait_treq(2, 400);
        checks++; if (qt(1) !== 5'd7) $display("FAIL retry_num got=%0d exp=7", qt(1)); else passed++;
        checks++; if (qtc(1) - t != 258) $display("FAIL retry_delay got=%0d exp=258", qtc(1) - t); else passed++;
        wait_msgs(1, 20);
        tick(3);
        checks++; if (qd(0) !== 32'h77 || qa(0) !== 64'h1_FEE0_0070) $display("FAIL retry_msg got=%h/%h exp=1fee00070/77", qa(0), qd(0)); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL retry_pend_clear got=%0d exp=0", pend_cnt); else passed++;
    endtask

    task automatic test_priority();
        int t;
        clear_logs();
        tbl[9] = {32'h1, 32'h99, 32'h2, 32'h0000_1000};
        request(0, 9);
        wait_rsp(1, 20);
        t = qrc(0);
        tbl[9][96] = 1'b0;
        for (int i = 0; i < 400 && cyc < t + 257; i++) begin
            @(posedge clk); #1;
        end
        request(2, 3);
        wait_treq(3, 400);
        wait_msgs(2, 20);
        tick(3);
        checks++; if (qg(1) !== 4'b0100) $display("FAIL prio_grant got=%h exp=4", qg(1)); else passed++;
        checks++; if (qgc(1) != t + 257) $display("FAIL prio_grant_cycle got=%0d exp=%0d", qgc(1), t + 257); else passed++;
        checks++; if (qt(1) !== 5'd3 || qt(2) !== 5'd9) $display("FAIL prio_order got=%0d,%0d exp=3,9", qt(1), qt(2)); else passed++;
        checks++; if (qtc(2) - qgc(1) != 261) $display("FAIL prio_retry_delay got=%0d exp=261", qtc(2) - qgc(1)); else passed++;
        checks++; if (qd(0) !== 32'h103 || qd(1) !== 32'h99) $display("FAIL prio_msgs got=%h,%h exp=103,99", qd(0), qd(1)); else passed++;
        checks++; if (qa(1) !== 64'h2_0000_1000) $display("FAIL prio_addr got=%h exp=200001000", qa(1)); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL prio_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
    endtask

    task automatic test_err_drop();
        clear_logs();
        tbl[12] = {32'h0, 32'hCC, 32'h0, 32'hFEE0_0002};
        request(3, 12);
        tick(10);
        checks++; if (qt(0) !== 5'd12) $display("FAIL err_tbl_num got=%0d exp=12", qt(0)); else passed++;
        checks++; if (err_cnt != 1) $display("FAIL err_pulse_cycles got=%0d exp=1", err_cnt); else passed++;
        checks++; if (m_addr.size() != 0) $display("FAIL err_no_msg got=%0d exp=0", m_addr.size()); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL err_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        tbl[14] = {32'h1, 32'hEE, 32'h0, 32'hFEE0_00E0};
        tbl[13] = {32'h0, 32'hDD, 32'h0, 32'hFEE0_00D0};
        request(0, 14);
        tick(8);
        checks++; if (pend_cnt !== 6'd1) $display("FAIL mid_pend_before got=%0d exp=1", pend_cnt); else passed++;
        msg_ready = 1'b0;
        request(1, 13);
        for (int i = 0; i < 20 && !msg_valid; i++) tick(1);
        tick(10);
        checks++; if (msg_valid !== 1'b1 || msg_data !== 32'hDD) $display("FAIL mid_stall got=%b/%h exp=1/dd", msg_valid, msg_data); else passed++;
        checks++; if (m_addr.size() != 0) $display("FAIL mid_no_accept got=%0d exp=0", m_addr.size()); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (msg_valid !== 1'b0) $display("FAIL mid_rst_msg_valid got=%b exp=0", msg_valid); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL mid_rst_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
        tick(2);
        rst_n = 1'b1;
        msg_ready = 1'b1;
        tick(3);
        checks++; if ({req_ready, tbl_req_valid, tbl_rsp_ready, msg_valid, err_drop} !== 8'h0)
            $display("FAIL post_rst_ctrl got=%h exp=0", {req_ready, tbl_req_valid, tbl_rsp_ready, msg_valid, err_drop}); else passed++;
        checks++; if ({tbl_req_num, msg_addr, msg_data} !== '0) $display("FAIL post_rst_data got=%h/%h/%h exp=0", tbl_req_num, msg_addr, msg_data); else passed++;
        checks++; if (pend_cnt !== '0) $display("FAIL post_rst_pend_cnt got=%0d exp=0", pend_cnt); else passed++;
    endtask

    initial begin
        req_valid = '0;
        req_num = '0;
        msg_ready = 1'b1;
        tbl_req_ready = 1'b1;
        for (int i = 0; i < NV; i++) tbl[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_masked_retry();
        test_priority();
        test_err_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
